// File: rtl/rate_tick_gen.sv
// rate_tick_gen: programmable tick generator with tick counter; optional sq_out toggle via TICK_TOGGLE_EN
module rate_tick_gen #(
  parameter int WIDTH = 27,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic             sq_out
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n, period_q, period_q_n;
  logic             tick_n, clr_tc;
  // next-state: en beats clear beats period change beats terminal count
  always_comb begin
    state_n    = state;
    count_n    = '0;
    period_q_n = period_q;
    tick_n     = 1'b0;
    clr_tc     = 1'b0;
    case (state)
      IDLE: begin
        state_n = en ? LOAD : IDLE;
        clr_tc  = clear;
      end
      LOAD: begin
        state_n    = en ? RUN : IDLE;
        period_q_n = period;
        clr_tc     = clear;
      end
      RUN: begin
        if (!en) state_n = IDLE;
        else if (clear) begin
          clr_tc  = 1'b1;
          state_n = LOAD;
        end
        else if (period != period_q) state_n = LOAD;
        else if (count == period_q) tick_n = 1'b1;
        else count_n = count + WIDTH'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      period_q   <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      period_q   <= period_q_n;
      tick       <= tick_n;
      tick_count <= clr_tc ? '0 : tick_count + CNT_W'(tick_n);
      running    <= state_n == RUN;
    end
  end
`ifdef TICK_TOGGLE_EN
  logic sq_q;
  // square wave flips on every tick, cleared with tick_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sq_q <= 1'b0;
    else if (clr_tc) sq_q <= 1'b0;
    else if (tick_n) sq_q <= ~sq_q;
  end
  assign sq_out = sq_q;
`else
  assign sq_out = 1'b0;
`endif
endmodule
